// File: rtl/pe_carry_resolver_if.sv
// Column-in / digit-out stream bundle for pe_carry_resolver.
// master drives columns in and accepts digits; slave is the resolver itself.
interface pe_carry_resolver_if #(
    parameter int unsigned K = 16,
    parameter int unsigned W = 48
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_s;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_digit;
    logic         out_last;

    modport master (
        output in_valid, in_s, in_last, out_ready,
        input  in_ready, out_valid, out_digit, out_last
    );

    modport slave (
        input  in_valid, in_s, in_last, out_ready,
        output in_ready, out_valid, out_digit, out_last
    );
endinterface

// File: rtl/pe_carry_resolver.sv
// Resolves redundant W-bit column accumulators into a radix-2^K digit stream, then flushes the carry.
// Optional column-count checking with err_len when PE_CARRY_RESOLVER_LENCHK_EN is defined.
module pe_carry_resolver #(
    parameter int unsigned K       = 16,
    parameter int unsigned W       = 48,
    parameter int unsigned N_WORDS = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_carry_resolver_if.slave   bus
`ifdef PE_CARRY_RESOLVER_LENCHK_EN
    ,
    output logic                 err_len
`endif
);
    localparam int unsigned CW     = W + 1 - K;
    localparam int unsigned NFLUSH = (CW + K - 1) / K;
    localparam int unsigned FCW    = (NFLUSH > 1) ? $clog2(NFLUSH) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e          state_q;
    logic [CW-1:0]   carry_q;
    logic [FCW-1:0]  flush_cnt_q;
    logic            out_valid_q;
    logic [K-1:0]    out_digit_q;
    logic            out_last_q;

    logic            out_free;
    logic            in_fire;
    logic            flush_last;
    logic [W:0]      acc;

    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        in_fire    = bus.in_valid && out_free && (state_q == StRun);
        flush_last = (flush_cnt_q == FCW'(NFLUSH - 1));
        // W+1 bits: in_s plus a CW-bit carry cannot overflow this width.
        acc        = {1'b0, bus.in_s} + {{K{1'b0}}, carry_q};
    end

    assign bus.in_ready  = out_free && (state_q == StRun);
    assign bus.out_valid = out_valid_q;
    assign bus.out_digit = out_digit_q;
    assign bus.out_last  = out_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            carry_q     <= '0;
            flush_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (in_fire) begin
                        out_digit_q <= acc[K-1:0];
                        carry_q     <= acc[W:K];
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        if (bus.in_last) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= '0;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StFlush: begin
                    // Always emit NFLUSH digits, zeros included, so frame length is fixed.
                    if (out_free) begin
                        out_digit_q <= carry_q[K-1:0];
                        out_valid_q <= 1'b1;
                        if (flush_last) begin
                            out_last_q  <= 1'b1;
                            carry_q     <= '0;
                            flush_cnt_q <= '0;
                            state_q     <= StRun;
                        end else begin
                            out_last_q  <= 1'b0;
                            carry_q     <= carry_q >> K;
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef PE_CARRY_RESOLVER_LENCHK_EN
    localparam int unsigned CNTW = $clog2(N_WORDS + 1);

    logic [CNTW-1:0] col_cnt_q;
    logic [CNTW:0]   col_cnt_inc;
    logic            err_len_q;

    assign col_cnt_inc = {1'b0, col_cnt_q} + 1'b1;
    assign err_len     = err_len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q <= '0;
            err_len_q <= 1'b0;
        end else if (in_fire) begin
            if (bus.in_last) begin
                col_cnt_q <= '0;
                if (col_cnt_inc != (CNTW + 1)'(N_WORDS)) begin
                    err_len_q <= 1'b1;
                end
            end else if (col_cnt_inc > (CNTW + 1)'(N_WORDS)) begin
                // Saturate rather than wrap; the error is already latched.
                err_len_q <= 1'b1;
            end else begin
                col_cnt_q <= col_cnt_inc[CNTW-1:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_pe_carry_resolver.sv
// Directed self-checking bench for pe_carry_resolver; digit stream captured by a negedge monitor.
module tb_pe_carry_resolver;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic rand_ready;

    logic [15:0] rx_d[$];
    logic        rx_l[$];
    logic [15:0] exp_d[$];
    logic        exp_l[$];

    pe_carry_resolver_if #(.K(16), .W(48)) bus ();

`ifdef PE_CARRY_RESOLVER_LENCHK_EN
    logic err_len;
    pe_carry_resolver #(.K(16), .W(48), .N_WORDS(17)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_len (err_len)
    );
`else
    pe_carry_resolver #(.K(16), .W(48), .N_WORDS(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Capture transfers and check that a stalled digit holds.
    logic        stall_prev;
    logic [15:0] digit_prev;
    logic        last_prev;
    initial begin
        stall_prev = 1'b0;
        digit_prev = '0;
        last_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev && !rst) begin
                n_cmp++;
                assert (bus.out_valid === 1'b1 && bus.out_digit === digit_prev &&
                        bus.out_last === last_prev)
                else begin
                    n_fail++;
                    $error("FAIL stall_hold: observed %h/%b expected %h/%b", bus.out_digit,
                           bus.out_last, digit_prev, last_prev);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                rx_d.push_back(bus.out_digit);
                rx_l.push_back(bus.out_last);
            end
            stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            digit_prev = bus.out_digit;
            last_prev  = bus.out_last;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [47:0] s, input logic last);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_last  = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("send_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_s     = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int guard;
        guard = 0;
        while (rx_d.size() < n && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 64'(rx_d.size()), 64'(n));
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 64'(rx_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            n_cmp++;
            assert (i < rx_d.size() && rx_d[i] === exp_d[i] && rx_l[i] === exp_l[i])
            else begin
                n_fail++;
                if (i < rx_d.size())
                    $error("FAIL %s[%0d]: observed %h/%b expected %h/%b", tag, i, rx_d[i],
                           rx_l[i], exp_d[i], exp_l[i]);
                else
                    $error("FAIL %s[%0d]: observed none expected %h/%b", tag, i, exp_d[i],
                           exp_l[i]);
            end
        end
    endtask

    task automatic expect_digit(input logic [15:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic clear_q();
        rx_d.delete();
        rx_l.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    logic [319:0] gold;
    logic [319:0] got;
    logic [47:0]  col;
    int           n_last;

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rand_ready   = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_s     = '0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_digit", 64'(bus.out_digit), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
`ifdef PE_CARRY_RESOLVER_LENCHK_EN
        chk("rst_err_len", 64'(err_len), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single-column frame: 1 data digit + 3 flush digits, input blocked during flush.
        clear_q();
        send(48'h0000_0001_2345, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        chk("post_flush_in_ready", 64'(bus.in_ready), 64'd1);
        wait_rx(4, "t1_count");
        expect_digit(16'h2345, 1'b0);
        expect_digit(16'h0001, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b1);
        check_stream("t1");

        // Maximum carry: two all-ones columns.
        clear_q();
        send(48'hFFFF_FFFF_FFFF, 1'b0);
        send(48'hFFFF_FFFF_FFFF, 1'b1);
        wait_rx(5, "t2_count");
        expect_digit(16'hFFFF, 1'b0);
        expect_digit(16'hFFFE, 1'b0);
        expect_digit(16'hFFFF, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0001, 1'b1);
        check_stream("t2");

        // 17 random columns under random backpressure, checked against the weighted sum.
        clear_q();
        gold = '0;
        rand_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            col  = {16'($urandom), 32'($urandom)};
            gold = gold + (320'(col) << (16 * i));
            send(col, (i == 16));
        end
        wait_rx(20, "t3_count");
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        got    = '0;
        n_last = 0;
        for (int i = 0; i < rx_d.size() && i < 20; i++) begin
            got[16*i +: 16] = rx_d[i];
            if (rx_l[i] === 1'b1) n_last++;
        end
        chk("t3_sum_lo", got[63:0], gold[63:0]);
        chk("t3_sum_mid", got[191:128], gold[191:128]);
        n_cmp++;
        assert (got === gold)
        else begin
            n_fail++;
            $error("FAIL t3_sum: observed %h expected %h", got, gold);
        end
        chk("t3_last_count", 64'(n_last), 64'd1);
        chk("t3_last_pos", 64'(rx_l.size() == 20 ? rx_l[19] : 1'b0), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames must not share carry.
        clear_q();
        send(48'h5, 1'b1);
        send(48'h7, 1'b1);
        wait_rx(8, "t4_count");
        expect_digit(16'h0005, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b1);
        expect_digit(16'h0007, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b1);
        check_stream("t4");

        // Reset during flush, just after the first flush digit is loaded.
        clear_q();
        send(48'h0000_0009_0003, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_rst_out_last", 64'(bus.out_last), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_digit(16'h0003, 1'b0);
        check_stream("t5_abort");
        clear_q();
        send(48'h10, 1'b1);
        wait_rx(4, "t5_count");
        expect_digit(16'h0010, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b0);
        expect_digit(16'h0000, 1'b1);
        check_stream("t5");

`ifdef PE_CARRY_RESOLVER_LENCHK_EN
        // Short frame sets err_len stickily; a correct frame after reset leaves it clear.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send(48'(i + 1), (i == 15));
        @(negedge clk);
        chk("t6_err_set", 64'(err_len), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_err_sticky", 64'(err_len), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) send(48'(i + 1), (i == 16));
        repeat (6) @(posedge clk);
        #1;
        chk("t6_err_clear", 64'(err_len), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_carry_resolver.md
Name: pe_carry_resolver

Overview:
- Consumes the 48-bit column accumulators that the Montgomery PE chain produces, one per cycle, least-significant column first.
- Resolves them into a non-redundant radix-2^K digit stream by propagating carries between columns.
- Sits between the PE array output and the result buffer / final-subtraction stage.
- After the last column it flushes the residual carry as extra digits, so the digit stream is the exact sum of all columns, each weighted by 2^(K·index).

Parameters:
- K, 16, digit width in bits; must be ≤ 24.
- W, 48, input accumulator width; matches the DSP P output.
- CW, W+1-K, carry register width (33 at the defaults).
- NFLUSH, ceil(CW/K), number of carry-flush digits emitted after the last column (3 at the defaults).
- N_WORDS, 17, expected number of columns per frame; used only by the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  column accumulator valid.
- in_ready  out  1  block can accept a column this cycle.
- in_s  in  W  column accumulator (unsigned).
- in_last  in  1  marks the final column of a frame.
- out_valid  out  1  digit valid.
- out_ready  in  1  downstream accepts the digit.
- out_digit  out  K  resolved digit.
- out_last  out  1  marks the final digit of a frame (the last flush digit).
- err_len  out  1  sticky length error; present only with the optional feature.

Behaviour:
- Reset is asynchronous, active-high, clock clk. While rst is asserted, or on the first cycle after release:
  - state=RUN, carry=0, flush count=0;
  - out_valid=0, out_digit=0, out_last=0;
  - err_len=0.
- Reset asserted mid-frame aborts the frame; no partial digit is emitted after release.
- Handshakes: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
- Output stage: a single register.
  - It is free when out_valid=0 or out_ready=1.
  - Producing a digit loads it and sets out_valid=1.
  - An output transfer with no new digit clears out_valid.
  - While out_valid=1 and out_ready=0, out_digit and out_last hold stable.
- RUN state:
  - in_ready = (output stage free) AND state==RUN.
  - On an input transfer: acc = in_s + carry, computed at W+1 bits with no overflow possible.
  - out_digit <= acc[K-1:0]; carry <= acc >> K; out_last <= 0.
  - Latency from input transfer to out_valid is 1 cycle.
  - If in_last=1, go to FLUSH with flush count = 0.
- FLUSH state:
  - in_ready = 0.
  - Each cycle the output stage is free: out_digit <= carry[K-1:0]; carry <= carry >> K; flush count increments.
  - Exactly NFLUSH digits are emitted, including zero digits; there is no early stop.
  - On the NFLUSH-th digit: out_last <= 1, carry <= 0, return to RUN.
  - A new frame may begin on the cycle after that digit is loaded.
- Frames with in_last on the first column are legal: the output is 1 + NFLUSH digits.
- Full throughput: with out_ready held high, one digit per cycle and no bubbles between frames apart from the NFLUSH flush cycles.
- in_s and in_last are ignored when no input transfer occurs.

Optional Feature:
- Macro: PE_CARRY_RESOLVER_LENCHK_EN.
- Defined:
  - Adds a column counter (width clog2(N_WORDS+1)) that increments on each input transfer and clears on an in_last transfer.
  - err_len is set when an in_last transfer occurs with count+1 ≠ N_WORDS, or when a non-last transfer would make the count exceed N_WORDS.
  - err_len stays set until rst; data flow is unaffected.
- Not defined: no counter and no err_len port; behaviour is otherwise identical.

Test Plan:
- Single column in_s=0x0000_0001_2345 with in_last=1, out_ready=1 → digits 0x2345, 0x0001, 0x0000, 0x0000; out_last only on the 4th; in_ready low for 3 cycles.
- Two columns 0xFFFF_FFFF_FFFF, then 0xFFFF_FFFF_FFFF with in_last=1 → digits 0xFFFF, 0xFFFE, 0xFFFF, 0x0000, 0x0001 (max-carry path, CW=33 exercised).
- 17 random columns with out_ready toggling pseudo-randomly → reassembled digits equal Σ in_s[i]·2^(16i) (golden model); out_digit stable while stalled; no lost or duplicated digits.
- Back-to-back frames ([5] last, then [7] last) with out_ready=1 → 0x0005, 0, 0, 0(last), 0x0007, 0, 0, 0(last); carry does not leak between frames.
- rst asserted mid-FLUSH after the first flush digit → out_valid=0 immediately; after release, a new frame [0x10] last yields 0x0010, 0, 0, 0.
- With PE_CARRY_RESOLVER_LENCHK_EN, a frame of 16 columns (N_WORDS=17) → err_len=1 after the in_last transfer and it stays 1; a correct 17-column frame after rst leaves err_len=0.
